// File: rtl/fb_reader_pkg.sv
// Shared types and default constants for the framebuffer column reader.
package fb_reader_pkg;
  localparam int DEF_WORDS_PER_COLUMN = 3456;
  localparam int DEF_NB_COLUMNS       = 128;
  localparam int DEF_RAM_LATENCY      = 2;
  localparam int DEF_FIFO_DEPTH       = 4;
  localparam int DEF_ADDR_W           = 19;
  localparam int DATA_W               = 30;

  typedef enum logic [1:0] {
    PRIME  = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } fb_state_e;

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction
endpackage

// File: rtl/fb_prefetch_fifo.sv
// Show-ahead synchronous FIFO: head always shows the oldest entry (0 when empty).
// Flush has priority over push and pop.
module fb_prefetch_fifo
  import fb_reader_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH,
  parameter int W     = DATA_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [W-1:0]                 wdata,
  output logic [W-1:0]                 head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q != CNT_W'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head  = (count_q == '0) ? '0 : mem_q[rd_ptr_q];
  assign count = count_q;
endmodule

// File: rtl/framebuffer_reader.sv
// Streams one column of framebuffer words to the driver controller via a prefetch FIFO.
// Optional FB_READER_UNDERRUN_CNT_EN adds a saturating underrun_count output.
module framebuffer_reader
  import fb_reader_pkg::*;
#(
  parameter int WORDS_PER_COLUMN = DEF_WORDS_PER_COLUMN,
  parameter int NB_COLUMNS       = DEF_NB_COLUMNS,
  parameter int RAM_LATENCY      = DEF_RAM_LATENCY,
  parameter int FIFO_DEPTH       = DEF_FIFO_DEPTH,
  parameter int ADDR_W           = DEF_ADDR_W
) (
  input  logic                          clk_lse,
  input  logic                          rst,
  input  logic                          driver_ready,
  input  logic                          column_ready,
  output logic                          ram_rd_en,
  output logic [ADDR_W-1:0]             ram_addr,
  input  logic [DATA_W-1:0]             ram_rdata,
  output logic [DATA_W-1:0]             framebuffer_dat,
  output logic                          fb_primed,
  output logic                          underrun,
  output logic [$clog2(NB_COLUMNS)-1:0] column_index,
  output fb_state_e                     state_dbg
`ifdef FB_READER_UNDERRUN_CNT_EN
  ,
  output logic [15:0]                   underrun_count
`endif
);
  localparam int COL_W       = $clog2(NB_COLUMNS);
  localparam int CNT_W       = $clog2(WORDS_PER_COLUMN + 1);
  localparam int FCNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int PRIME_LEVEL = min_int(FIFO_DEPTH, WORDS_PER_COLUMN);

  fb_state_e              state_q, state_d;
  logic [COL_W-1:0]       column_index_q, column_index_d;
  logic [ADDR_W-1:0]      col_base_q, col_base_d;
  logic [CNT_W-1:0]       fetched_q, fetched_d, popped_q, popped_d;
  logic [RAM_LATENCY-1:0] vld_q, vld_d;
  logic [FCNT_W-1:0]      fifo_count;
  logic [DATA_W-1:0]      fifo_head;
  logic                   fifo_pop, fifo_push;
  int                     inflight;

  always_comb begin
    inflight = 0;
    for (int i = 0; i < RAM_LATENCY; i++) inflight = inflight + int'(vld_q[i]);
  end

  // State register
  always_ff @(posedge clk_lse) begin
    if (rst) state_q <= PRIME;
    else     state_q <= state_d;
  end

  // Next state: column_ready restarts priming from any state
  always_comb begin
    state_d = state_q;
    if (column_ready) begin
      state_d = PRIME;
    end else begin
      case (state_q)
        PRIME:   if (int'(fifo_count) >= PRIME_LEVEL) state_d = STREAM;
        STREAM:  if (fifo_pop && popped_q == CNT_W'(WORDS_PER_COLUMN - 1)) state_d = DONE;
        default: state_d = state_q;
      endcase
    end
  end

  // Handshake: framebuffer_dat is valid whenever fb_primed=1 and driver_ready in that
  // cycle consumes it; driver_ready without fb_primed is an underrun. column_ready wins.
  always_comb begin
    fb_primed = 1'b0;
    fifo_pop  = 1'b0;
    underrun  = 1'b0;
    ram_rd_en = 1'b0;
    if (!rst) begin
      fb_primed = (state_q == STREAM) && (fifo_count != '0);
      if (!column_ready) begin
        fifo_pop  = driver_ready && fb_primed;
        underrun  = driver_ready && !fb_primed;
        ram_rd_en = (state_q != DONE) && (fetched_q != CNT_W'(WORDS_PER_COLUMN)) &&
                    (int'(fifo_count) + inflight - int'(fifo_pop) < FIFO_DEPTH);
      end
    end
  end

  always_comb begin
    column_index_d = column_index_q;
    col_base_d     = col_base_q;
    fetched_d      = fetched_q;
    popped_d       = popped_q;
    vld_d          = (vld_q << 1) | RAM_LATENCY'(ram_rd_en);
    if (ram_rd_en) fetched_d = fetched_q + 1'b1;
    if (fifo_pop)  popped_d  = popped_q + 1'b1;
    if (column_ready) begin
      vld_d     = '0;
      fetched_d = '0;
      popped_d  = '0;
      if (column_index_q == COL_W'(NB_COLUMNS - 1)) begin
        column_index_d = '0;
        col_base_d     = '0;
      end else begin
        column_index_d = column_index_q + 1'b1;
        col_base_d     = col_base_q + ADDR_W'(WORDS_PER_COLUMN);
      end
    end
  end

  always_ff @(posedge clk_lse) begin
    if (rst) begin
      column_index_q <= '0;
      col_base_q     <= '0;
      fetched_q      <= '0;
      popped_q       <= '0;
      vld_q          <= '0;
    end else begin
      column_index_q <= column_index_d;
      col_base_q     <= col_base_d;
      fetched_q      <= fetched_d;
      popped_q       <= popped_d;
      vld_q          <= vld_d;
    end
  end

  // A return is accepted only when its valid bit leaves the latency pipe
  assign fifo_push = vld_q[RAM_LATENCY-1];

  fb_prefetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (DATA_W)
  ) u_fifo (
    .clk   (clk_lse),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (column_ready),
    .wdata (ram_rdata),
    .head  (fifo_head),
    .count (fifo_count)
  );

  assign ram_addr        = col_base_q + ADDR_W'(fetched_q);
  assign framebuffer_dat = rst ? '0 : fifo_head;
  assign column_index    = column_index_q;
  assign state_dbg       = state_q;

`ifdef FB_READER_UNDERRUN_CNT_EN
  logic [15:0] underrun_count_q;
  always_ff @(posedge clk_lse) begin
    if (rst) underrun_count_q <= '0;
    else if (underrun && underrun_count_q != 16'hFFFF) underrun_count_q <= underrun_count_q + 16'd1;
  end
  assign underrun_count = underrun_count_q;
`endif

  fifo_bound_a: assert property (@(posedge clk_lse) disable iff (rst)
    int'(fifo_count) <= FIFO_DEPTH);
endmodule
